compressor_3to1_serial_seq: RTL and testbench

Sequencer that computes the full-width sum of three NUM_BITS operands by time-multiplexing a single 8-bit 3:1 compressor slice, one byte per cycle, LSB byte first. Between bytes it keeps the two carry bits: the 3:2-stage carry and the final-adder carry. It sits beside the modular-squaring datapath as the low-area reduction path for wide three-operand sums, such as partial-product folding and final carry resolution. A valid/ready handshake is used on both input and output.

---
 rtl/compressor_3to1_serial_seq.sv | 90 +++++++++
 tb/tb_compressor_3to1_serial_seq.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/compressor_3to1_serial_seq.sv
// Serial three-operand adder: one 8-bit 3:1 compressor slice reused per byte,
// LSB byte first, carrying the 3:2 carry and final-adder carry between bytes.
module compressor_3to1_serial_seq #(
  parameter int NUM_BITS = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [NUM_BITS-1:0] a,
  input  logic [NUM_BITS-1:0] b,
  input  logic [NUM_BITS-1:0] c,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [NUM_BITS+1:0] sum,
  output logic                busy
);

  localparam int NUM_CHUNKS = NUM_BITS / 8;
  localparam int KW = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NUM_CHUNKS - 1);

  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

  state_t              state;
  logic [NUM_BITS-1:0] a_q, b_q, c_q;
  logic                c3, ci;
  logic [KW-1:0]       k;
  logic [NUM_BITS+1:0] sum_q;

  logic [7:0] ps, gc, cv;
  logic [8:0] fa;
  logic       c3_nxt, ci_nxt;
  logic [1:0] top;
  logic       accept;

  // 3:2 stage folds the bytes into sum/carry vectors; the incoming c3 fills the
  // vacated carry bit 0 and the outgoing bit-7 carry becomes the next c3.
  assign ps     = a_q[7:0] ^ b_q[7:0] ^ c_q[7:0];
  assign gc     = (a_q[7:0] & b_q[7:0]) | (a_q[7:0] & c_q[7:0]) | (b_q[7:0] & c_q[7:0]);
  assign cv     = {gc[6:0], c3};
  assign fa     = {1'b0, ps} + {1'b0, cv} + {8'b0, ci};
  assign c3_nxt = gc[7];
  assign ci_nxt = fa[8];
  assign top    = {1'b0, c3_nxt} + {1'b0, ci_nxt};

  assign in_ready  = (state == IDLE) | ((state == HOLD) & out_ready);
  assign accept    = in_valid & in_ready;
  assign out_valid = (state == HOLD);
  assign busy      = (state == RUN);
  assign sum       = sum_q;

  // Operands shift right one byte per RUN cycle so the slice always sees byte 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      a_q   <= '0;
      b_q   <= '0;
      c_q   <= '0;
      c3    <= 1'b0;
      ci    <= 1'b0;
      k     <= '0;
      sum_q <= '0;
    end else if (state == RUN) begin
      a_q <= a_q >> 8;
      b_q <= b_q >> 8;
      c_q <= c_q >> 8;
      c3  <= c3_nxt;
      ci  <= ci_nxt;
      sum_q[{k, 3'b000} +: 8] <= fa[7:0];
      if (k == K_LAST) begin
        sum_q[NUM_BITS +: 2] <= top;
        state <= HOLD;
      end else begin
        k <= k + 1'b1;
      end
    end else if (accept) begin
      a_q   <= a;
      b_q   <= b;
      c_q   <= c;
      c3    <= 1'b0;
      ci    <= 1'b0;
      k     <= '0;
      state <= RUN;
    end else if ((state == HOLD) && out_ready) begin
      state <= IDLE;
    end
  end

endmodule

// File: tb/tb_compressor_3to1_serial_seq.sv
// Random and directed checks of the serial 3-operand adder against a plain
// a+b+c reference, including backpressure, back-to-back and mid-run reset.
module tb_compressor_3to1_serial_seq;

  localparam int NUM_BITS   = 64;
  localparam int NUM_CHUNKS = NUM_BITS / 8;
  localparam int N_RAND     = 1000;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                in_valid;
  logic                in_ready;
  logic [NUM_BITS-1:0] a, b, c;
  logic                out_valid;
  logic                out_ready;
  logic [NUM_BITS+1:0] sum;
  logic                busy;

  int total = 0;
  int bad   = 0;

  compressor_3to1_serial_seq #(.NUM_BITS(NUM_BITS)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .c(c), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [NUM_BITS+1:0] model(input logic [NUM_BITS-1:0] x, y, z);
    return {2'b00, x} + {2'b00, y} + {2'b00, z};
  endfunction

  function automatic logic [NUM_BITS-1:0] rnd();
    return {$urandom, $urandom};
  endfunction

  task automatic check(input string tag, input logic [NUM_BITS+1:0] obs, input logic [NUM_BITS+1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for out_valid, optionally scrambling inputs while RUN is active.
  task automatic wait_out(input bit scramble, output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
      if (!out_valid && scramble) begin
        in_valid = 1'($urandom);
        a = rnd(); b = rnd(); c = rnd();
      end
    end while (!out_valid && cycles < 100);
    in_valid = 1'b0;
  endtask

  task automatic apply_stimulus(input logic [NUM_BITS-1:0] x, y, z, input bit scramble, input string tag);
    logic [NUM_BITS+1:0] exp;
    int n, cyc;
    @(negedge clk);
    a = x; b = y; c = z; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    exp = model(x, y, z);
    @(posedge clk);
    #1 in_valid = 1'b0;
    wait_out(scramble, cyc);
    check({tag, "_latency"}, (NUM_BITS+2)'(cyc), (NUM_BITS+2)'(NUM_CHUNKS + 1));
    check({tag, "_sum"}, sum, exp);
    check({tag, "_in_ready_hold"}, (NUM_BITS+2)'(in_ready), (NUM_BITS+2)'(out_ready));
  endtask

  initial begin
    logic [NUM_BITS+1:0] q[$];
    logic [NUM_BITS+1:0] exp, exp2;
    int sent, recv, cyc, last_ov, n;
    bit take;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; c = '0;
    #12;
    check("reset_in_ready", (NUM_BITS+2)'(in_ready), 1);
    check("reset_out_valid", (NUM_BITS+2)'(out_valid), 0);
    check("reset_busy", (NUM_BITS+2)'(busy), 0);
    check("reset_sum", sum, 0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] directed cases");
    apply_stimulus('1, '1, '1, 1'b0, "all_ones");
    apply_stimulus(64'h00FF, 64'h0001, 64'h0000, 1'b0, "carry_byte1");
    apply_stimulus('0, '0, '0, 1'b0, "zeros");
    apply_stimulus('1, 64'h1, '0, 1'b0, "carry_full");
    apply_stimulus(rnd(), rnd(), rnd(), 1'b1, "scramble_run");

    $display("[TB] back-to-back random stream");
    sent = 0; recv = 0; cyc = 0; last_ov = -1;
    @(negedge clk);
    a = rnd(); b = rnd(); c = rnd(); in_valid = 1'b1; out_ready = 1'b1;
    while (recv < N_RAND && cyc < N_RAND * 10 + 100) begin
      if (cyc > 0) @(negedge clk);
      cyc++;
      if (out_valid) begin
        if (q.size() > 0) check("stream_sum", sum, q.pop_front());
        else check("stream_spurious", 1, 0);
        if (last_ov >= 0) check("stream_interval", (NUM_BITS+2)'(cyc - last_ov), (NUM_BITS+2)'(NUM_CHUNKS + 1));
        last_ov = cyc;
        recv++;
      end
      take = in_valid && in_ready;
      if (take) q.push_back(model(a, b, c));
      @(posedge clk);
      #1;
      if (take) begin
        sent++;
        if (sent < N_RAND) begin
          a = rnd(); b = rnd(); c = rnd();
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    check("stream_count", (NUM_BITS+2)'(recv), (NUM_BITS+2)'(N_RAND));
    @(negedge clk);

    $display("[TB] backpressure");
    out_ready = 1'b0;
    a = rnd(); b = rnd(); c = rnd(); in_valid = 1'b1;
    exp = model(a, b, c);
    @(posedge clk);
    #1 in_valid = 1'b0;
    wait_out(1'b0, cyc);
    check("bp_latency", (NUM_BITS+2)'(cyc), (NUM_BITS+2)'(NUM_CHUNKS + 1));
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("bp_out_valid", (NUM_BITS+2)'(out_valid), 1);
      check("bp_sum", sum, exp);
      check("bp_in_ready", (NUM_BITS+2)'(in_ready), 0);
    end
    a = rnd(); b = rnd(); c = rnd(); in_valid = 1'b1; out_ready = 1'b1;
    exp2 = model(a, b, c);
    #1 check("bp_release_in_ready", (NUM_BITS+2)'(in_ready), 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    check("bp_accept_busy", (NUM_BITS+2)'(busy), 1);
    check("bp_accept_out_valid", (NUM_BITS+2)'(out_valid), 0);
    wait_out(1'b0, cyc);
    check("bp_next_sum", sum, exp2);

    $display("[TB] reset during RUN");
    @(negedge clk);
    a = rnd(); b = rnd(); c = rnd(); in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_reset_in_ready", (NUM_BITS+2)'(in_ready), 1);
    check("mid_reset_out_valid", (NUM_BITS+2)'(out_valid), 0);
    check("mid_reset_busy", (NUM_BITS+2)'(busy), 0);
    check("mid_reset_sum", sum, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    apply_stimulus('1, '1, '1, 1'b0, "after_reset_ones");
    apply_stimulus(rnd(), rnd(), rnd(), 1'b0, "after_reset_rand");

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
